pool_2x2_unit: RTL and testbench
================================

// Module: pool_2x2_unit
// PURPOSE
//  2x2 / stride-2 pooling engine ahead of the ofmap output mux; produces its pool_out input.
//  Consumes ReLU'd psums streamed row-major, one pixel per in_valid beat.
//  Emits one pooled pixel per 2x2 window.
//  Sits between the ReLU stage and the ofmap mux; the controller starts it per output channel.
// PARAMETERS
//  DATA_W    `psum_wid  pixel width; signed two's complement
//  MAX_COLS  64         max ifmap columns; sizes the half-row line buffer (MAX_COLS/2 entries)
//  CNT_W     7          width of the row/col counters and of col_num/row_num
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        1-cycle pulse; latches col_num/row_num and arms a new frame
//  col_num    in   CNT_W    frame columns (2..MAX_COLS)
//  row_num    in   CNT_W    frame rows (>=2)
//  pool_mode  in   1        0=max, 1=average (honoured only with POOL_AVG_EN)
//  in_valid   in   1        in_data is valid this cycle; gaps are allowed
//  in_data    in   DATA_W   input pixel
//  pool_out   out  DATA_W   pooled pixel, registered
//  out_valid  out  1        pool_out is valid (1-cycle pulse per window)
//  busy       out  1        frame in progress
//  done       out  1        1-cycle pulse after the last window is emitted
// BEHAVIOUR
//  - Reset: pool_out=0, out_valid=0, busy=0, done=0, counters=0, FSM=IDLE. Line buffer contents are don't-care.
//  - FSM IDLE -> EVEN_ROW on start.
//    - IDLE: start latches cfg and clears counters.
//    - EVEN_ROW -> ODD_ROW at row end; ODD_ROW -> EVEN_ROW at row end; ODD_ROW -> DONE after the last pair row.
//    - DONE -> IDLE unconditionally; done=1 for that one cycle.
//  - busy=1 in EVEN_ROW/ODD_ROW.
//  - start outside IDLE is ignored. in_valid in IDLE/DONE is dropped.
//  - Counters advance only on in_valid. col_cnt wraps at col_num-1; row_cnt increments on that wrap.
//  - Horizontal pair: even col_cnt beat is held in h_reg; the odd beat combines with h_reg (max or sum).
//  - EVEN_ROW: the pair result is written to line_buf[col_cnt>>1].
//  - ODD_ROW: the pair result is combined with line_buf[col_cnt>>1].
//    - The window result is registered to pool_out with out_valid=1 on the next cycle.
//    - Latency: 1 clk from the 4th pixel's beat.
//  - Max compare is signed; ties keep either value (equal).
//  - Odd col_num: the last column of each row is consumed but discarded.
//  - Odd row_num: the last row is consumed but discarded; DONE is entered after that row.
//  - Read and write of the same line_buf index never coincide (separate row phases).
//  - Async reset mid-frame aborts immediately; the next frame needs a fresh start.
// CONFIGURATION
//  - POOL_AVG_EN defined:
//    - pool_mode=1 selects average: signed sum of 4 in DATA_W+2 bits, arithmetic >>2 (floor), truncated to DATA_W.
//    - The line buffer stores a DATA_W+1 pair sum in this mode.
//  - POOL_AVG_EN undefined: pool_mode is ignored, max only, line buffer is DATA_W wide.
// STRUCTURE
//  - Shared include Define.v: `psum_wid, pool mode encodings (`POOL_MAX=0, `POOL_AVG=1), MAX_COLS default.
//  - Sub-module pool_line_buf: 1R1W register array, MAX_COLS/2 x (DATA_W or DATA_W+1), synchronous write, combinational read.
//  - FSM, counters, h_reg and the output register live in the top module.
// TESTING
//  1. 4x4 frame, values 0..15 row-major, max -> out 5,7,13,15; done 1 clk after the 4th out_valid.
//  2. Signed 2x2 {-3,-8,-1,-5}, max -> pool_out=-1.
//     With POOL_AVG_EN and avg: sum -17 -> -5 (floor).
//  3. 5x3 frame (odd cols and rows) -> exactly 2 outputs; col 4 and row 2 discarded; done still pulses.
//  4. Random in_valid gaps (~50% duty) on case 1 -> identical outputs and order; no out_valid in gap-only cycles.
//  5. Assert rst_n low after the 6th pixel of case 1 -> all outputs 0 at once.
//     Start again -> clean correct frame. A start pulse while busy -> no effect.

Source files
------------

// File: rtl/pool_2x2_unit_pkg.sv
// Shared definitions for the 2x2 / stride-2 pooling engine: default widths,
// pool mode encodings and the control FSM state type.
package pool_2x2_unit_pkg;

    // Default pixel (psum) width.
    localparam int PSUM_WID     = 16;
    // Default maximum ifmap column count.
    localparam int MAX_COLS_DEF = 64;
    // Default width of the row/column counters.
    localparam int CNT_W_DEF    = 7;

    // pool_mode encodings.
    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVEN_ROW = 2'd1,
        ST_ODD_ROW  = 2'd2,
        ST_DONE     = 2'd3
    } pool_state_e;

endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer for the pooling engine: 1R1W register array with a
// synchronous write port and a combinational read port. Contents are not reset.
module pool_line_buf #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 16,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one horizontal pair result per write strobe.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read is combinational so the odd row can combine in the same beat.
    always_comb begin
        rd_data = mem_q[rd_addr];
    end

endmodule

// File: rtl/pool_2x2_unit.sv
// 2x2 / stride-2 pooling engine. Consumes a row-major pixel stream and emits
// one pooled pixel per 2x2 window. Max pooling always; average pooling is
// compiled in when the macro POOL_AVG_EN is defined (pool_mode=1 selects it).
module pool_2x2_unit
    import pool_2x2_unit_pkg::*;
#(
    parameter int DATA_W   = PSUM_WID,
    parameter int MAX_COLS = MAX_COLS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         col_num,
    input  logic [CNT_W-1:0]         row_num,
    input  logic                     pool_mode,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] pool_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH = MAX_COLS / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef POOL_AVG_EN
    // Pair sums need one extra bit to avoid overflow before the final average.
    localparam int BUF_W = DATA_W + 1;
`else
    localparam int BUF_W = DATA_W;
`endif

    pool_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cols_q, cols_d;
    logic [CNT_W-1:0]         rows_q, rows_d;
    logic [CNT_W-1:0]         col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0]         row_cnt_q, row_cnt_d;
    logic signed [DATA_W-1:0] h_reg_q, h_reg_d;
    logic signed [DATA_W-1:0] pool_out_q, pool_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     last_col;
    logic                     last_row;
    logic                     buf_wr_en;
    logic [AW-1:0]            buf_addr;
    logic signed [BUF_W-1:0]  pair_result;
    logic signed [BUF_W-1:0]  buf_rd_data;
    logic signed [DATA_W-1:0] win_result;

`ifdef POOL_AVG_EN
    logic                     mode_q, mode_d;
    logic signed [BUF_W-1:0]  pair_sum;
    logic signed [BUF_W-1:0]  pair_max;
    logic signed [BUF_W:0]    win_sum;
    logic signed [BUF_W:0]    win_avg;
    logic signed [BUF_W-1:0]  win_max;

    // Horizontal pair and full-window combine, max or floor-average.
    always_comb begin
        pair_sum    = $signed({h_reg_q[DATA_W-1], h_reg_q}) + $signed({in_data[DATA_W-1], in_data});
        pair_max    = (h_reg_q > in_data) ? $signed({h_reg_q[DATA_W-1], h_reg_q})
                                          : $signed({in_data[DATA_W-1], in_data});
        pair_result = (mode_q == POOL_AVG) ? pair_sum : pair_max;
        win_sum     = $signed({pair_result[BUF_W-1], pair_result})
                    + $signed({buf_rd_data[BUF_W-1], buf_rd_data});
        win_avg     = win_sum >>> 2;
        win_max     = (pair_result > buf_rd_data) ? pair_result : buf_rd_data;
        win_result  = (mode_q == POOL_MAX) ? DATA_W'(win_max) : DATA_W'(win_avg);
    end
`else
    logic unused_mode;
    assign unused_mode = (pool_mode == POOL_MAX) | (pool_mode == POOL_AVG);

    // Horizontal pair and full-window combine, signed max only.
    always_comb begin
        pair_result = (h_reg_q > in_data) ? h_reg_q : in_data;
        win_result  = (pair_result > buf_rd_data) ? pair_result : buf_rd_data;
    end
`endif

    assign last_col = (col_cnt_q == cols_q - CNT_W'(1));
    assign last_row = (row_cnt_q == rows_q - CNT_W'(1));
    assign buf_addr = AW'(col_cnt_q >> 1);

    pool_line_buf #(
        .DEPTH (DEPTH),
        .WIDTH (BUF_W)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (buf_wr_en),
        .wr_addr (buf_addr),
        .wr_data (pair_result),
        .rd_addr (buf_addr),
        .rd_data (buf_rd_data)
    );

    // Next-state logic: frame FSM, counters, horizontal hold register and output register.
    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        h_reg_d     = h_reg_q;
        pool_out_d  = pool_out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        buf_wr_en   = 1'b0;
`ifdef POOL_AVG_EN
        mode_d      = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cols_d    = col_num;
                    rows_d    = row_num;
                    col_cnt_d = '0;
                    row_cnt_d = '0;
`ifdef POOL_AVG_EN
                    mode_d    = pool_mode;
`endif
                    state_d   = ST_EVEN_ROW;
                end
            end
            ST_EVEN_ROW, ST_ODD_ROW: begin
                if (in_valid) begin
                    if (!col_cnt_q[0]) begin
                        h_reg_d = in_data;
                    end else if (state_q == ST_EVEN_ROW) begin
                        buf_wr_en = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        pool_out_d  = win_result;
                    end
                    if (last_col) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + CNT_W'(1);
                        if (last_row) begin
                            state_d = ST_DONE;
                        end else if (state_q == ST_EVEN_ROW) begin
                            state_d = ST_ODD_ROW;
                        end else begin
                            state_d = ST_EVEN_ROW;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_EVEN_ROW) || (state_d == ST_ODD_ROW);
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            h_reg_q     <= '0;
            pool_out_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q      <= POOL_MAX;
`endif
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            h_reg_q     <= h_reg_d;
            pool_out_q  <= pool_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef POOL_AVG_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign pool_out  = pool_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pool_2x2_unit.sv
// Self-checking bench for pool_2x2_unit: table of single-window vectors,
// hand-written frame sequences and random frames against a window model.
module tb_pool_2x2_unit;

    localparam int DW = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [6:0]           col_num;
    logic [6:0]           row_num;
    logic                 pool_mode;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic signed [DW-1:0] pool_out;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    pool_2x2_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .col_num   (col_num),
        .row_num   (row_num),
        .pool_mode (pool_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .pool_out  (pool_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int pix [256];
    int got_q [$];
    int cyc = 0;
    int lastOutCycle = 0;
    int doneCycle = 0;
    int doneCount = 0;
    int gapViolations = 0;
    logic prevInValid = 1'b0;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int expMax;
        int expAvg;
    } vec_t;

    vec_t vecs [7];

    // Record whether the last edge carried an input beat.
    always @(posedge clk) prevInValid <= in_valid;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (out_valid) begin
            got_q.push_back(int'(pool_out));
            lastOutCycle = cyc;
            if (!prevInValid) gapViolations = gapViolations + 1;
        end
        if (done) begin
            doneCount = doneCount + 1;
            doneCycle = cyc;
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drive one frame from pix[]; optional input gaps, a stray start mid-frame,
    // or an early return after abortAt beats (0 = run to completion).
    task automatic applyStimulus(input int cols, input int rows, input int gapPct,
                                 input bit injectStart, input int abortAt);
        got_q.delete();
        doneCount = 0;
        gapViolations = 0;
        @(posedge clk); #1;
        col_num = 7'(cols);
        row_num = 7'(rows);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < cols * rows; i++) begin
            for (int g = 0; g < 20 && int'($urandom_range(99)) < gapPct; g++) begin
                in_valid = 1'b0;
                in_data = DW'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data = DW'(pix[i]);
            if (injectStart && i == 3) begin
                start = 1'b1;
                col_num = 7'd2;
                row_num = 7'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = 1'b0;
            col_num = 7'(cols);
            row_num = 7'(rows);
            if (abortAt == i + 1) return;
        end
        for (int k = 0; k < 20 && doneCount == 0; k++) @(posedge clk);
        checkOutput("done_seen", int'(doneCount > 0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: every complete 2x2 window, row-major, signed max.
    task automatic checkFrame(input string name, input int cols, input int rows);
        int expQ [$];
        int m;
        for (int r = 0; r + 1 < rows; r += 2) begin
            for (int c = 0; c + 1 < cols; c += 2) begin
                m = pix[r * cols + c];
                if (pix[r * cols + c + 1] > m) m = pix[r * cols + c + 1];
                if (pix[(r + 1) * cols + c] > m) m = pix[(r + 1) * cols + c];
                if (pix[(r + 1) * cols + c + 1] > m) m = pix[(r + 1) * cols + c + 1];
                expQ.push_back(m);
            end
        end
        checkOutput({name, "_count"}, got_q.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("%s_out%0d", name, i), got_q[i], expQ[i]);
        end
        checkOutput({name, "_done_pulses"}, doneCount, 1);
        checkOutput({name, "_gap_outputs"}, gapViolations, 0);
    endtask

    task automatic loadRamp(input int n);
        for (int i = 0; i < n; i++) pix[i] = i;
    endtask

    initial begin
        int exp1 [4];
        logic [DW-1:0] rnd;
        int rc;
        int rr;

        exp1[0] = 5; exp1[1] = 7; exp1[2] = 13; exp1[3] = 15;
        vecs[0] = '{a: 0,      b: 1,      c: 2,      d: 3,      expMax: 3,      expAvg: 1};
        vecs[1] = '{a: -3,     b: -8,     c: -1,     d: -5,     expMax: -1,     expAvg: -5};
        vecs[2] = '{a: 7,      b: 7,      c: 7,      d: 7,      expMax: 7,      expAvg: 7};
        vecs[3] = '{a: -32768, b: -32768, c: -32768, d: -32768, expMax: -32768, expAvg: -32768};
        vecs[4] = '{a: 32767,  b: 32767,  c: 32767,  d: 32767,  expMax: 32767,  expAvg: 32767};
        vecs[5] = '{a: 100,    b: -100,   c: -200,   d: 50,     expMax: 100,    expAvg: -38};
        vecs[6] = '{a: -1,     b: 0,      c: 0,      d: 0,      expMax: 0,      expAvg: -1};

        rst_n = 1'b0;
        start = 1'b0;
        col_num = '0;
        row_num = '0;
        pool_mode = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        #12;
        checkOutput("reset_pool_out", int'(pool_out), 0);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single-window vectors, max mode.
        for (int v = 0; v < 7; v++) begin
            pix[0] = vecs[v].a; pix[1] = vecs[v].b; pix[2] = vecs[v].c; pix[3] = vecs[v].d;
            pool_mode = 1'b0;
            applyStimulus(2, 2, 0, 1'b0, 0);
            checkOutput($sformatf("vec%0d_count", v), got_q.size(), 1);
            if (got_q.size() > 0) checkOutput($sformatf("vec%0d_max", v), got_q[0], vecs[v].expMax);
`ifdef POOL_AVG_EN
            pool_mode = 1'b1;
            applyStimulus(2, 2, 0, 1'b0, 0);
            checkOutput($sformatf("vec%0d_avg_count", v), got_q.size(), 1);
            if (got_q.size() > 0) checkOutput($sformatf("vec%0d_avg", v), got_q[0], vecs[v].expAvg);
            pool_mode = 1'b0;
`endif
        end

        // 4x4 ramp: outputs 5,7,13,15, done one cycle after the last output.
        loadRamp(16);
        applyStimulus(4, 4, 0, 1'b0, 0);
        checkOutput("ramp4x4_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            checkOutput($sformatf("ramp4x4_out%0d", i), got_q[i], exp1[i]);
        checkOutput("ramp4x4_done_delay", doneCycle - lastOutCycle, 1);

        // 5x3 frame: last column and last row discarded.
        loadRamp(15);
        applyStimulus(5, 3, 0, 1'b0, 0);
        checkOutput("odd5x3_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            checkOutput("odd5x3_out0", got_q[0], 6);
            checkOutput("odd5x3_out1", got_q[1], 8);
        end
        checkFrame("odd5x3", 5, 3);

        // 4x4 ramp with ~50% input gaps.
        loadRamp(16);
        applyStimulus(4, 4, 50, 1'b0, 0);
        checkFrame("gaps4x4", 4, 4);

        // Mid-frame reset after the 6th pixel.
        loadRamp(16);
        applyStimulus(4, 4, 0, 1'b0, 6);
        checkOutput("abort_pre_pool_out", int'(pool_out), 5);
        checkOutput("abort_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pool_out", int'(pool_out), 0);
        checkOutput("abort_out_valid", int'(out_valid), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_done", int'(done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Beats while idle are dropped and produce nothing.
        got_q.delete();
        in_valid = 1'b1;
        in_data = 16'sd999;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_beats_outputs", got_q.size(), 0);

        // Fresh frame after the abort, with a stray start while busy.
        applyStimulus(4, 4, 0, 1'b1, 0);
        checkFrame("restart4x4", 4, 4);

        // Random frames with random gaps.
        for (int t = 0; t < 6; t++) begin
            rc = int'($urandom_range(12, 2));
            rr = int'($urandom_range(9, 2));
            for (int i = 0; i < rc * rr; i++) begin
                rnd = DW'($urandom);
                pix[i] = int'($signed(rnd));
            end
            applyStimulus(rc, rr, 30, 1'b0, 0);
            checkFrame($sformatf("rand%0d_%0dx%0d", t, rc, rr), rc, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
